// File: rtl/spart_rx_buffer_if.sv
// Purpose : bundles the receiver-side capture handshake and the processor read port of spart_rx_buffer.
// Latency : n/a (signal bundle only).
// Backpress: n/a; the receiver holds rda until rda_clr, the processor polls status before reading data.
// Ports   : rx_data/rda/rda_clr  - byte handoff from rx_spart
//           iocs/iorw/ioaddr     - processor read request, rd_data returned one clock later
//           rx_avail/overflow/count - live FIFO status
interface spart_rx_buffer_if #(
  parameter int AW = 3
);
  logic [7:0]  rx_data;
  logic        rda;
  logic        rda_clr;
  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  rd_data;
  logic        rx_avail;
  logic        overflow;
  logic [AW:0] count;

  // master: the receiver + processor side that drives requests
  modport master (
    output rx_data, rda, iocs, iorw, ioaddr,
    input  rda_clr, rd_data, rx_avail, overflow, count
  );

  // slave: the buffer itself
  modport slave (
    input  rx_data, rda, iocs, iorw, ioaddr,
    output rda_clr, rd_data, rx_avail, overflow, count
  );
endinterface

// File: rtl/spart_rx_buffer.sv
// Purpose : DEPTH-entry byte FIFO between rx_spart and the processor, with data/status read registers.
// Latency : byte stored on the clock after rda rises (rda_clr pulses then); rd_data valid one clock after rd.
// Backpress: none toward rx_spart; a byte arriving while full is dropped and latches the sticky overflow flag.
// Ports   : clk, rst (synchronous, active low)
//           bus.rx_data/rda -> capture, bus.rda_clr <- one-cycle acknowledge
//           bus.iocs/iorw/ioaddr -> read request (00 data, 01 status, 10/11 read as zero)
//           bus.rd_data, bus.rx_avail, bus.overflow, bus.count <- read data and status
module spart_rx_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  spart_rx_buffer_if.slave    bus
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;

  // Storage and datapath state
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [7:0]    rd_data_q;
  logic          rda_clr_q;
  logic          rda_q;

  // Decoded control for this cycle
  logic          push;
  logic          rd;
  logic          data_rd;
  logic          status_rd;
  logic          pop;
  logic          full;
  logic          empty;
  logic          accept;
  logic          drop;
  logic [5:0]    count6;
  logic [7:0]    status_byte;

  // Only a rising edge of rda is a new byte; rda held high is the same byte.
  assign push      = bus.rda & ~rda_q;

  assign rd        = bus.iocs & bus.iorw;
  assign data_rd   = rd & (bus.ioaddr == ADDR_DATA);
  assign status_rd = rd & (bus.ioaddr == ADDR_STATUS);

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);

  // A data read on an empty FIFO returns zero and does not move rd_ptr.
  assign pop       = data_rd & ~empty;

  // When full, a same-cycle pop frees the slot the push needs. The pop reads the
  // old entry (non-blocking), so wr_ptr==rd_ptr here is safe.
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;

  // Status count field is 6 bits wide regardless of DEPTH.
  assign count6      = 6'(count_q);
  assign status_byte = {overflow_q, ~empty, count6};

  // RAM has no reset; its contents before the first write are never read
  // because count gates every pop.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rda_clr_q  <= 1'b0;
      // Treat rda as already high so a byte still presented across reset
      // release is not captured a second time.
      rda_q      <= 1'b1;
    end else begin
      rda_q     <= bus.rda;
      // Acknowledge every edge, including dropped ones, so rx_spart can move on.
      rda_clr_q <= push;

      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Reading status clears the sticky flag, but a drop in the same cycle wins.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (status_rd) begin
        overflow_q <= 1'b0;
      end

      if (rd) begin
        case (bus.ioaddr)
          ADDR_DATA:   rd_data_q <= pop ? mem[rd_ptr] : 8'h00;
          ADDR_STATUS: rd_data_q <= status_byte;
          default:     rd_data_q <= 8'h00;
        endcase
      end
    end
  end

  assign bus.rda_clr  = rda_clr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rx_avail = ~empty;
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_spart_rx_buffer.sv
// Purpose : directed and random stimulus for spart_rx_buffer, checked against a queue-based model.
// Latency : model predicts outputs one clock after each sampled input set.
// Backpress: n/a (bench).
module tb_spart_rx_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spart_rx_buffer_if #(.AW(AW)) bus ();

  spart_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored bytes plus expected registered outputs.
  logic [7:0] q[$];
  bit         m_ovf  = 1'b0;
  logic [7:0] m_rd   = 8'h00;
  bit         m_clr  = 1'b0;
  bit         m_rdaq = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the inputs presented now, advance, then compare.
  task automatic cycle();
    bit         push, rd, pop, drop;
    int         sz;
    logic [7:0] status;
    logic       rst_s;
    logic [1:0] addr_s;
    logic [7:0] din_s;
    logic       rda_s;
    sz     = q.size();
    rst_s  = rst;
    rda_s  = bus.rda;
    din_s  = bus.rx_data;
    addr_s = bus.ioaddr;
    push   = rda_s && !m_rdaq;
    rd     = bus.iocs && bus.iorw;
    pop    = rd && (addr_s == 2'd0) && (sz != 0);
    drop   = push && (sz == DEPTH) && !pop;
    status = {m_ovf, (sz != 0), 6'(sz)};
    @(posedge clk);
    #1;
    if (!rst_s) begin
      q.delete();
      m_ovf  = 1'b0;
      m_rd   = 8'h00;
      m_clr  = 1'b0;
      m_rdaq = 1'b1;
    end else begin
      m_rdaq = rda_s;
      m_clr  = push;
      if (rd) begin
        if (addr_s == 2'd0)      m_rd = pop ? q[0] : 8'h00;
        else if (addr_s == 2'd1) m_rd = status;
        else                     m_rd = 8'h00;
      end
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(din_s);
      if (drop) m_ovf = 1'b1;
      else if (rd && addr_s == 2'd1) m_ovf = 1'b0;
    end
    check("count",    32'(bus.count),  32'(q.size()));
    check("rx_avail", 32'(bus.rx_avail), 32'(q.size() != 0));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("rda_clr",  32'(bus.rda_clr),  32'(m_clr));
    check("rd_data",  32'(bus.rd_data),  32'(m_rd));
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rda     = 1'b1;
    cycle();
    bus.rda     = 1'b0;
    cycle();
  endtask

  task automatic io_read(input logic [1:0] addr);
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b1;
    bus.ioaddr = addr;
    cycle();
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    bus.rda     = 1'b1;
    bus.rx_data = 8'h55;
    bus.iocs    = 1'b0;
    bus.iorw    = 1'b0;
    bus.ioaddr  = 2'b00;

    // Reset with rda held high, then release: nothing captured.
    cycle();
    cycle();
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_count",    32'(bus.count),    0);
    check("rst_rda_clr",  32'(bus.rda_clr),  0);
    check("rst_rd_data",  32'(bus.rd_data),  0);
    check("rst_overflow", 32'(bus.overflow), 0);
    bus.rda = 1'b0;
    cycle();

    // Single byte: ack one clock after rda rises, then read it back.
    bus.rx_data = 8'h6a;
    bus.rda     = 1'b1;
    cycle();
    check("single_clr",   32'(bus.rda_clr),  1);
    check("single_count", 32'(bus.count),    1);
    check("single_avail", 32'(bus.rx_avail), 1);
    cycle();
    check("single_clr_off", 32'(bus.rda_clr), 0);
    bus.rda = 1'b0;
    cycle();
    io_read(2'b00);
    check("single_data",   32'(bus.rd_data), 32'h6a);
    check("single_count0", 32'(bus.count),   0);

    // Ordering and pointer wrap: pops start alongside the 7th push.
    for (int i = 1; i <= 12; i++) begin
      bus.rx_data = 8'(i);
      bus.rda     = 1'b1;
      if (i > 6) begin
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
      end
      cycle();
      if (i > 6) check("wrap_data", 32'(bus.rd_data), 32'(i - 6));
      bus.iocs = 1'b0; bus.iorw = 1'b0;
      bus.rda  = 1'b0;
      cycle();
    end
    for (int i = 7; i <= 12; i++) begin
      io_read(2'b00);
      check("wrap_tail", 32'(bus.rd_data), 32'(i));
    end

    // Overflow: 9 pushes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) push_byte(8'hA0 + 8'(i));
    check("ovf_count", 32'(bus.count),    8);
    check("ovf_flag",  32'(bus.overflow), 1);
    io_read(2'b01);
    check("ovf_status1", 32'(bus.rd_data), 32'hC8);
    io_read(2'b01);
    check("ovf_status2", 32'(bus.rd_data), 32'h48);
    for (int i = 0; i < 8; i++) begin
      io_read(2'b00);
      check("ovf_data", 32'(bus.rd_data), 32'hA0 + i);
    end

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) push_byte(8'hB0 + 8'(i));
    bus.rx_data = 8'hF3;
    bus.rda     = 1'b1;
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
    cycle();
    check("fullpp_data",  32'(bus.rd_data),  32'hB0);
    check("fullpp_count", 32'(bus.count),    8);
    check("fullpp_ovf",   32'(bus.overflow), 0);
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.rda = 1'b0;
    cycle();
    for (int i = 1; i < 8; i++) begin
      io_read(2'b00);
      check("fullpp_drain", 32'(bus.rd_data), 32'hB0 + i);
    end
    io_read(2'b00);
    check("fullpp_last", 32'(bus.rd_data), 32'hF3);

    // Empty reads and reserved addresses.
    io_read(2'b00);
    check("empty_data", 32'(bus.rd_data), 0);
    check("empty_count", 32'(bus.count), 0);
    push_byte(8'h5A);
    io_read(2'b11);
    check("rsvd3", 32'(bus.rd_data), 0);
    io_read(2'b01);
    check("status_one", 32'(bus.rd_data), 32'h41);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
    repeat (3) cycle();
    check("write_hold", 32'(bus.rd_data), 32'h41);
    check("write_nopop", 32'(bus.count), 1);
    bus.iocs = 1'b0; bus.iorw = 1'b1;
    cycle();
    check("nocs_hold", 32'(bus.rd_data), 32'h41);
    bus.iorw = 1'b0;
    io_read(2'b00);
    check("after_hold", 32'(bus.rd_data), 32'h5A);

    // Push and pop together while empty: no write-through.
    bus.rx_data = 8'h77;
    bus.rda     = 1'b1;
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
    cycle();
    check("emptypp_data",  32'(bus.rd_data), 0);
    check("emptypp_count", 32'(bus.count),   1);
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.rda = 1'b0;
    cycle();
    io_read(2'b00);
    check("emptypp_read", 32'(bus.rd_data), 32'h77);

    // Random traffic, including occasional mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) != 0);
      bus.rda     = ($urandom_range(0, 2) != 0);
      bus.rx_data = 8'($urandom);
      bus.iocs    = ($urandom_range(0, 2) == 0);
      bus.iorw    = ($urandom_range(0, 3) != 0);
      bus.ioaddr  = ($urandom_range(0, 3) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
      cycle();
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_rx_buffer.md
Name: spart_rx_buffer

Overview:
- Receive-side buffer directly downstream of rx_spart.
- Captures each byte rx_spart flags with rda into a DEPTH-entry FIFO, then returns a one-cycle acknowledge so the receiver can drop rda.
- Exposes a processor-side read port (data and status registers) on the SPART ioaddr/iorw bus, so the processor is not forced to service every byte before the next one arrives.

Parameters:
DEPTH, 8, number of byte entries; must be a power of two, 2..64
AW, 3, pointer width, log2(DEPTH)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-low reset (rst==0 at posedge resets)
rx_data  input  8  received byte from rx_spart; valid while rda==1
rda  input  1  receive-data-available from rx_spart
rda_clr  output  1  one-cycle pulse acknowledging a captured byte
iocs  input  1  chip select for the processor read port
iorw  input  1  1 = read; writes (0) are ignored by this block
ioaddr  input  2  00 = data, 01 = status; 10/11 reserved (read as 8'h00)
rd_data  output  8  registered read data
rx_avail  output  1  FIFO non-empty (count != 0)
overflow  output  1  sticky: a byte was dropped because the FIFO was full
count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst==0 at posedge):
  - wr_ptr, rd_ptr and count cleared to 0; overflow=0; rd_data=8'h00; rda_clr=0.
  - rda_q (registered rda) set to 1, so a byte already held on rda when reset releases is not captured.
  - FIFO RAM contents are don't-care.
  - Reset applies mid-operation; an in-flight capture or read is abandoned.
- Capture:
  - push = rda & ~rda_q (rising edge of rda).
  - If push and the FIFO is not full: mem[wr_ptr] <= rx_data; wr_ptr increments mod DEPTH (natural AW-bit wrap).
  - If push and the FIFO is full, with no simultaneous pop: byte dropped; overflow <= 1; pointers unchanged.
  - rda_clr = 1 in the cycle after any push, including a dropped push; otherwise 0.
  - A new capture needs rda to fall and rise again; rda held high never re-captures.
- Read port (rd = iocs & iorw):
  - ioaddr 00, count != 0: rd_data <= mem[rd_ptr]; rd_ptr increments mod DEPTH. This is a pop.
  - ioaddr 00, count == 0: rd_data <= 8'h00; no pointer change; no error flag.
  - ioaddr 01: rd_data <= {overflow, rx_avail, 6'(count)}, with count zero-extended/truncated to 6 bits. Overflow clears to 0 in the same cycle unless an overflow drop occurs that cycle (set wins).
  - ioaddr 10/11: rd_data <= 8'h00.
  - No read: rd_data holds its value.
  - Latency: rd_data valid one clock after the cycle rd is sampled.
- Count and status:
  - count: +1 on accepted push only; -1 on pop only; unchanged when both occur in one cycle.
  - Push and pop in the same cycle while full: both accepted, no overflow, count stays DEPTH.
  - Push and pop in the same cycle while empty: pop returns 8'h00, push stored, count becomes 1. There is no write-through.
  - rx_avail = (count != 0), combinational from count.
  - full = (count == DEPTH).
- No state machine beyond the pointer/count datapath. The edge detector is the only control state.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with rda=1 held, then release -> no capture, count=0, rda_clr stays 0, rd_data=8'h00, overflow=0.
- Single byte: rx_data=8'h6a, rda rises -> rda_clr pulses exactly one cycle later; count=1, rx_avail=1. Data read -> rd_data=8'h6a next cycle, count=0.
- Ordering and wrap: push 8'h01..8'h0C while popping after the 6th push, so pointers wrap -> reads return 01..0C in order; count never exceeds 8.
- Overflow: push 9 bytes (8'hA0..8'hA8) with no reads -> count=8, overflow=1 after the 9th. Status read -> 8'hC8; a second status read -> 8'h48. Data reads return A0..A7.
- Simultaneous push/pop when full (DEPTH=8, count=8, pop on the cycle of rda's rising edge with rx_data=8'hF3) -> overflow stays 0, count=8, and F3 is read last.
- Empty read and reserved address: data read at count=0 -> 8'h00, pointers unchanged. ioaddr=11 read -> 8'h00. iorw=0 cycles leave rd_data unchanged.
